// File: rtl/fault_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : fault_input_filter
// Description : Two-flop synchroniser plus per-bit debounce for the motor
//               error and fail-sensor lines feeding the machine controller.
//               Emits a single-cycle CHANGE strobe whenever any filtered bit
//               toggles.
// Revision    : 1.0 - initial release
// ============================================================================
module fault_input_filter #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [4:0] MOT_ERR,
    input  logic [2:0] FAIL_SENSn,
    output logic [4:0] MOT_ERR_F,
    output logic [2:0] FAIL_SENSn_F,
    output logic       CHANGE
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1, so clog2 is enough;
    // a 1-cycle filter still gets a 1-bit (constant zero) counter.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int NCH   = 8;

    // Idle (no fault) level per channel: MOT_ERR bits low, FAIL_SENSn bits high.
    localparam logic [NCH-1:0]   IDLE = 8'b0000_0111;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] filt;
    logic [NCH-1:0] toggle;

    // Both input groups are handled as one 8-bit vector of identical channels.
    assign raw = {MOT_ERR, FAIL_SENSn};

    // Two-flop synchroniser; reset loads idle levels so no spurious edge
    // is seen after reset release.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_chan
            logic [CNT_W-1:0] cnt;

            // The filtered bit flips once the differing level has been seen
            // on DEBOUNCE_CYCLES consecutive edges.
            assign toggle[i] = (sync2[i] != filt[i]) && (cnt == TERM);

            // Qualification counter: any return to the filtered level or a
            // completed qualification restarts the window from zero.
            always_ff @(posedge CLK) begin
                if (!RSTn) begin
                    cnt <= '0;
                end else if ((sync2[i] == filt[i]) || toggle[i]) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Filtered levels and the change strobe share the same edge.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            filt   <= IDLE;
            CHANGE <= 1'b0;
        end else begin
            filt   <= filt ^ toggle;
            CHANGE <= |toggle;
        end
    end

    assign MOT_ERR_F    = filt[7:3];
    assign FAIL_SENSn_F = filt[2:0];

endmodule
`default_nettype wire

// File: tb/tb_fault_input_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fault_input_filter
// Description : Directed self-checking bench for fault_input_filter with the
//               default 4-cycle debounce window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fault_input_filter;

    logic       CLK;
    logic       RSTn;
    logic [4:0] MOT_ERR;
    logic [2:0] FAIL_SENSn;
    logic [4:0] MOT_ERR_F;
    logic [2:0] FAIL_SENSn_F;
    logic       CHANGE;

    int errors;
    int checks;

    logic [4:0] exp_m;
    logic [2:0] exp_s;
    logic       exp_c;

    fault_input_filter #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .MOT_ERR      (MOT_ERR),
        .FAIL_SENSn   (FAIL_SENSn),
        .MOT_ERR_F    (MOT_ERR_F),
        .FAIL_SENSn_F (FAIL_SENSn_F),
        .CHANGE       (CHANGE)
    );

    // 100 MHz clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 ns past it for sampling.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Return all channels to idle through a short reset.
    task automatic back_to_idle();
        RSTn       = 1'b0;
        MOT_ERR    = 5'b00000;
        FAIL_SENSn = 3'b111;
        tick();
        tick();
        RSTn = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RSTn       = 1'b0;
        MOT_ERR    = 5'b10101;
        FAIL_SENSn = 3'b000;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {5'b00000, 3'b111, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%b/%b/%b exp=00000/111/0",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE);
            end
        end
        RSTn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_m = (k >= 6) ? 5'b10101 : 5'b00000;
            exp_s = (k >= 6) ? 3'b000 : 3'b111;
            exp_c = (k == 6);
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {exp_m, exp_s, exp_c}) begin
                errors++;
                $display("FAIL reset_release k=%0d got=%b/%b/%b exp=%b/%b/%b",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE, exp_m, exp_s, exp_c);
            end
        end
        back_to_idle();
    endtask

    task automatic test_latency();
        MOT_ERR = 5'b00001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_m = (k >= 6) ? 5'b00001 : 5'b00000;
            exp_c = (k == 6);
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {exp_m, 3'b111, exp_c}) begin
                errors++;
                $display("FAIL latency_rise k=%0d got=%b/%b/%b exp=%b/111/%b",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE, exp_m, exp_c);
            end
        end
        MOT_ERR = 5'b00000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_m = (k >= 6) ? 5'b00000 : 5'b00001;
            exp_c = (k == 6);
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {exp_m, 3'b111, exp_c}) begin
                errors++;
                $display("FAIL latency_fall k=%0d got=%b/%b/%b exp=%b/111/%b",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE, exp_m, exp_c);
            end
        end
    endtask

    task automatic test_glitch();
        FAIL_SENSn = 3'b110;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) FAIL_SENSn = 3'b111;
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {5'b00000, 3'b111, 1'b0}) begin
                errors++;
                $display("FAIL glitch k=%0d got=%b/%b/%b exp=00000/111/0",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
        for (int k = 1; k <= 11; k++) begin
            MOT_ERR = (k <= 8) ? {2'b00, pat[k-1], 2'b00} : 5'b00100;
            tick();
            exp_m = (k >= 10) ? 5'b00100 : 5'b00000;
            exp_c = (k == 10);
            checks++;
            if ({MOT_ERR_F, CHANGE} !== {exp_m, exp_c}) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b/%b exp=%b/%b",
                         k, MOT_ERR_F, CHANGE, exp_m, exp_c);
            end
        end
        back_to_idle();
    endtask

    task automatic test_simultaneous();
        MOT_ERR    = 5'b11111;
        FAIL_SENSn = 3'b000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_m = (k >= 6) ? 5'b11111 : 5'b00000;
            exp_s = (k >= 6) ? 3'b000 : 3'b111;
            exp_c = (k == 6);
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {exp_m, exp_s, exp_c}) begin
                errors++;
                $display("FAIL simultaneous k=%0d got=%b/%b/%b exp=%b/%b/%b",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE, exp_m, exp_s, exp_c);
            end
        end
        back_to_idle();
    endtask

    task automatic test_back_to_back();
        MOT_ERR = 5'b00001;
        tick();
        MOT_ERR = 5'b00011;
        for (int k = 2; k <= 9; k++) begin
            tick();
            exp_m = {3'b000, (k >= 7), (k >= 6)};
            exp_c = (k == 6) || (k == 7);
            checks++;
            if ({MOT_ERR_F, CHANGE} !== {exp_m, exp_c}) begin
                errors++;
                $display("FAIL back_to_back k=%0d got=%b/%b exp=%b/%b",
                         k, MOT_ERR_F, CHANGE, exp_m, exp_c);
            end
        end
        back_to_idle();
    endtask

    task automatic test_reset_mid();
        MOT_ERR = 5'b00010;
        tick();
        tick();
        tick();
        RSTn = 1'b0;
        tick();
        checks++;
        if ({MOT_ERR_F, CHANGE} !== {5'b00000, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_hold got=%b/%b exp=00000/0", MOT_ERR_F, CHANGE);
        end
        RSTn = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_m = (k >= 6) ? 5'b00010 : 5'b00000;
            exp_c = (k == 6);
            checks++;
            if ({MOT_ERR_F, FAIL_SENSn_F, CHANGE} !== {exp_m, 3'b111, exp_c}) begin
                errors++;
                $display("FAIL reset_mid k=%0d got=%b/%b/%b exp=%b/111/%b",
                         k, MOT_ERR_F, FAIL_SENSn_F, CHANGE, exp_m, exp_c);
            end
        end
        back_to_idle();
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        RSTn       = 1'b0;
        MOT_ERR    = 5'b00000;
        FAIL_SENSn = 3'b111;
        test_reset();
        test_latency();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fault_input_filter.md
Name: fault_input_filter

Overview:
Input conditioning stage directly upstream of the machine-control block. Synchronises the asynchronous motor-error and fail-sensor lines into the CLK domain and debounces each bit independently. Delivers clean, glitch-free MOT_ERR_F / FAIL_SENSn_F vectors that connect straight to the controller's MOT_ERR / FAIL_SENSn inputs. Also provides a one-cycle change strobe for event logging.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a new level must hold before the filtered output follows it; legal range 1..65535.
CNT_W, derived (not overridable), clog2(DEBOUNCE_CYCLES) with a minimum of 1; width of each per-bit counter.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RSTn  input  1  synchronous reset, active-low.
MOT_ERR  input  5  raw motor error lines, active-high, asynchronous to CLK.
FAIL_SENSn  input  3  raw fail-sensor lines, active-low, asynchronous to CLK.
MOT_ERR_F  output  5  debounced motor errors, registered.
FAIL_SENSn_F  output  3  debounced fail sensors, registered.
CHANGE  output  1  one-cycle pulse when any filtered bit changes, registered.

Interface decisions:
- One clock, CLK. Reset RSTn is synchronous and active-low; it is sampled only on the CLK rising edge.

Behaviour:
- Reset (RSTn = 0 at a rising edge). On the next edge:
  - MOT_ERR_F = 5'b00000 and FAIL_SENSn_F = 3'b111 (idle, no fault).
  - CHANGE = 0.
  - All counters = 0.
  - Sync flops load the same idle values: 0 for MOT_ERR bits, 1 for FAIL_SENSn bits.
- Reset dominates every other event, including a counter reaching terminal count on the same edge.
- Channels: 8 identical, independent bit channels (MOT_ERR[4:0], FAIL_SENSn[2:0]).
- Synchroniser: 2-flop chain per bit (s1 <= raw, s2 <= s1). No logic between s1 and s2.
- Per-channel debounce, evaluated each edge using s2, filtered bit f and counter cnt:
  - s2 == f: cnt <= 0, f unchanged.
  - s2 != f and cnt == DEBOUNCE_CYCLES-1: f <= s2, cnt <= 0.
  - s2 != f otherwise: cnt <= cnt + 1.
- Any return of s2 to f before terminal count clears cnt. Bounces restart the qualification window; partial counts never accumulate.
- Latency: a raw level change that is stable before edge 0 appears on the filtered output after edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges total. For the default of 4 this is 6 edges, 60 ns at 100 MHz.
- Rejection: a raw pulse shorter than DEBOUNCE_CYCLES clock periods never reaches the output. Only pulses whose synchronised width is at least DEBOUNCE_CYCLES pass.
- CHANGE:
  - Registered; high for exactly one cycle, on the same edge at which one or more filtered bits toggle.
  - Several bits toggling on the same edge produce a single pulse.
  - Toggles on consecutive edges produce CHANGE high on consecutive cycles.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible. For DEBOUNCE_CYCLES = 1, cnt is constant 0 and the output follows s2 one edge later.
- Polarity is carried through unchanged. No inversion is applied; FAIL_SENSn_F stays active-low.
- No combinational path from any input to any output.

Test Plan:
- Reset: RSTn = 0 for 2 cycles with MOT_ERR = 5'b10101, FAIL_SENSn = 3'b000 -> MOT_ERR_F = 00000, FAIL_SENSn_F = 111, CHANGE = 0 throughout reset; then RSTn = 1 -> outputs become 10101 / 000 after 6 edges, with one CHANGE pulse.
- Latency and pass: DEBOUNCE_CYCLES = 4, MOT_ERR = 00001 held 10 cycles -> MOT_ERR_F[0] rises exactly 6 edges after the input change and falls 6 edges after release; CHANGE pulses once at each transition.
- Glitch reject: FAIL_SENSn = 110 for 3 cycles, then 111 -> FAIL_SENSn_F stays 111, CHANGE stays 0.
- Bounce restart: MOT_ERR[2] pattern 1,1,1,0,1,1,1,1 (one value per cycle) -> MOT_ERR_F[2] rises only after the last 4-cycle stable run, i.e. 6 edges after the final 0->1 transition.
- Simultaneous bits: MOT_ERR = 11111 and FAIL_SENSn = 000 on the same edge -> all 8 filtered bits toggle on the same edge, with a single one-cycle CHANGE pulse.
- Reset mid-count: MOT_ERR = 00010 held; RSTn = 0 for 1 cycle after 3 edges -> MOT_ERR_F stays 00000, counter restarts; output rises 6 edges after RSTn returns to 1.
